// File: rtl/queue_arb_pkg.sv
// Shared types and constants for the queue write-port arbiter.
package queue_arb_pkg;

  // Arbiter FSM: IDLE arbitrates freely, LOCKED serves only the packet owner.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  localparam int DATA_W_DEFAULT = 16;
  localparam int STAT_W         = 32;

  // Saturating increment for the statistics counters.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: the first eligible requester at
// or after rr_ptr (wrapping past N_REQ-1 back to 0) wins.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] eligible,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             grant_vld,
  output logic [IDX_W-1:0] grant_idx
);

  localparam int CW = IDX_W + 1;

  logic [CW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest eligible one is kept.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + CW'(k);
      if (cand >= CW'(N_REQ)) begin
        cand = cand - CW'(N_REQ);
      end
      if (eligible[cand[IDX_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/queue_wr_arbiter.sv
// Round-robin arbiter sharing the queue write port among N_REQ result
// producers. Multi-word packets keep the grant until their last word so
// records never interleave. One output word is buffered and held while the
// queue reports full.
// Optional: define QUEUE_ARB_STATS_EN to add per-requester word counters and a
// full-stall cycle counter.
module queue_wr_arbiter
  import queue_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_last,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ack,
  output logic [DATA_W-1:0]         wr_port,
  output logic                      wr_req,
`ifdef QUEUE_ARB_STATS_EN
  output logic [N_REQ*STAT_W-1:0]   stat_words,
  output logic [STAT_W-1:0]         stat_full_stall,
`endif
  input  logic                      q_full
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t        state_reg;
  logic [IDX_W-1:0]  owner_reg;
  logic [IDX_W-1:0]  rr_ptr_reg;
  logic              ob_valid_reg;
  logic [DATA_W-1:0] ob_data_reg;

  logic [N_REQ-1:0]  owner_mask;
  logic [N_REQ-1:0]  eligible;
  logic              grant_vld;
  logic [IDX_W-1:0]  grant_idx;
  logic [DATA_W-1:0] grant_data;
  logic              grant_last;
  logic [IDX_W-1:0]  rr_ptr_next;
  logic              load;
  logic              accept;

  assign wr_req  = ob_valid_reg & ~q_full;
  assign wr_port = ob_data_reg;
  // The buffer can take a word when empty or when it drains this cycle.
  assign load    = ~ob_valid_reg | wr_req;
  // Gated by reset so no ack escapes while reset is asserted.
  assign accept  = load & grant_vld & reset_n;

  // While a packet is in flight only its owner may be granted.
  always_comb begin
    owner_mask            = '0;
    owner_mask[owner_reg] = 1'b1;
    eligible              = (state_reg == ST_LOCKED) ? (req_valid & owner_mask) : req_valid;
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr_reg),
    .grant_vld (grant_vld),
    .grant_idx (grant_idx)
  );

  // Select the granted requester's word, last flag and successor pointer.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        grant_data = req_data[i*DATA_W +: DATA_W];
      end
    end
    grant_last  = req_last[grant_idx];
    rr_ptr_next = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  // Ack is one-hot on the granted requester in the cycle its word is taken.
  always_comb begin
    req_ack = '0;
    if (accept) begin
      req_ack[grant_idx] = 1'b1;
    end
  end

  // Arbitration FSM together with the output buffer and round-robin pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      owner_reg    <= '0;
      rr_ptr_reg   <= '0;
      ob_valid_reg <= 1'b0;
      ob_data_reg  <= '0;
    end else begin
      if (accept) begin
        ob_valid_reg <= 1'b1;
        ob_data_reg  <= grant_data;
        case (state_reg)
          ST_IDLE: begin
            rr_ptr_reg <= rr_ptr_next;
            if (!grant_last) begin
              state_reg <= ST_LOCKED;
              owner_reg <= grant_idx;
            end
          end
          ST_LOCKED: begin
            if (grant_last) begin
              state_reg <= ST_IDLE;
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end else if (wr_req) begin
        // Word drained and nothing to replace it.
        ob_valid_reg <= 1'b0;
      end
    end
  end

`ifdef QUEUE_ARB_STATS_EN
  logic [STAT_W-1:0] stat_words_reg [N_REQ];
  logic [STAT_W-1:0] stat_full_stall_reg;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stat_words
      // Count words accepted from requester gi.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          stat_words_reg[gi] <= '0;
        end else if (req_ack[gi]) begin
          stat_words_reg[gi] <= sat_inc(stat_words_reg[gi]);
        end
      end
      assign stat_words[gi*STAT_W +: STAT_W] = stat_words_reg[gi];
    end
  endgenerate

  // Count cycles where a buffered word is blocked by a full queue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_full_stall_reg <= '0;
    end else if (ob_valid_reg && q_full) begin
      stat_full_stall_reg <= sat_inc(stat_full_stall_reg);
    end
  end

  assign stat_full_stall = stat_full_stall_reg;
`endif

endmodule

// File: tb/tb_queue_wr_arbiter.sv
// Directed testbench for queue_wr_arbiter (N_REQ=4, DATA_W=16).
module tb_queue_wr_arbiter;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 16;

  logic                    clk;
  logic                    reset_n;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ack;
  logic [DATA_W-1:0]       wr_port;
  logic                    wr_req;
  logic                    q_full;
`ifdef QUEUE_ARB_STATS_EN
  logic [N_REQ*32-1:0]     stat_words;
  logic [31:0]             stat_full_stall;
`endif

  int n_checks;
  int n_pass;
  int n_cyc;

  localparam logic [63:0] D_BASE = 64'h4444_3333_2222_1111;

  queue_wr_arbiter #(
    .N_REQ  (N_REQ),
    .DATA_W (DATA_W)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_last        (req_last),
    .req_data        (req_data),
    .req_ack         (req_ack),
    .wr_port         (wr_port),
    .wr_req          (wr_req),
`ifdef QUEUE_ARB_STATS_EN
    .stat_words      (stat_words),
    .stat_full_stall (stat_full_stall),
`endif
    .q_full          (q_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs just after the rising edge, return at the falling edge.
  task automatic cyc(input logic rn, input logic [3:0] v, input logic [3:0] l,
                     input logic [63:0] d, input logic qf);
    @(posedge clk);
    #1;
    reset_n   = rn;
    req_valid = v;
    req_last  = l;
    req_data  = d;
    q_full    = qf;
    @(negedge clk);
    n_cyc++;
    $display("cyc %0d rst_n=%b valid=%b last=%b q_full=%b -> ack=%b wr_req=%b wr_port=%h",
             n_cyc, rn, v, l, qf, req_ack, wr_req, wr_port);
  endtask

  logic [3:0]  exp_ack [5];
  logic [15:0] exp_wr  [5];

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    n_cyc     = 0;
    reset_n   = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    q_full    = 1'b0;

    // Reset held with every requester valid: all outputs stay zero.
    cyc(1'b0, 4'hF, 4'hF, D_BASE, 1'b0);
    check("rst_ack",    req_ack, 4'h0);
    check("rst_wr_req", wr_req,  1'b0);
    check("rst_wr_port", wr_port, 16'h0);
    cyc(1'b0, 4'hF, 4'hF, D_BASE, 1'b0);
    check("rst_ack2", req_ack, 4'h0);

    // Release: single-word packets from all four, round-robin 0,1,2,3,0.
    exp_ack[0] = 4'b0001; exp_wr[0] = 16'h0000;
    exp_ack[1] = 4'b0010; exp_wr[1] = 16'h1111;
    exp_ack[2] = 4'b0100; exp_wr[2] = 16'h2222;
    exp_ack[3] = 4'b1000; exp_wr[3] = 16'h3333;
    exp_ack[4] = 4'b0001; exp_wr[4] = 16'h4444;
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 4'hF, 4'hF, D_BASE, 1'b0);
      check($sformatf("rr_ack%0d", k), req_ack, exp_ack[k]);
      check($sformatf("rr_wr_req%0d", k), wr_req, (k != 0));
      if (k != 0) check($sformatf("rr_wr_port%0d", k), wr_port, exp_wr[k]);
    end
    cyc(1'b1, 4'h0, 4'hF, D_BASE, 1'b0);
    check("rr_tail_ack",  req_ack, 4'h0);
    check("rr_tail_port", wr_port, 16'h1111);
    check("rr_tail_req",  wr_req,  1'b1);
    cyc(1'b1, 4'h0, 4'hF, D_BASE, 1'b0);
    check("rr_drained", wr_req, 1'b0);

    // Packet from req 2 (A1,A2,A3) with others waiting; req 3 goes next.
    cyc(1'b1, 4'b0010, 4'hF, D_BASE, 1'b0);
    check("pk_pre_ack", req_ack, 4'b0010);
    cyc(1'b1, 4'hF, 4'b1011, 64'h4444_00A1_2222_1111, 1'b0);
    check("pk_a1_ack",  req_ack, 4'b0100);
    check("pk_a1_port", wr_port, 16'h2222);
    cyc(1'b1, 4'hF, 4'b1011, 64'h4444_00A2_2222_1111, 1'b0);
    check("pk_a2_ack",  req_ack, 4'b0100);
    check("pk_a2_port", wr_port, 16'h00A1);
    cyc(1'b1, 4'hF, 4'hF, 64'h4444_00A3_2222_1111, 1'b0);
    check("pk_a3_ack",  req_ack, 4'b0100);
    check("pk_a3_port", wr_port, 16'h00A2);
    cyc(1'b1, 4'b1011, 4'hF, D_BASE, 1'b0);
    check("pk_next_ack",  req_ack, 4'b1000);
    check("pk_next_port", wr_port, 16'h00A3);
    cyc(1'b1, 4'h0, 4'hF, D_BASE, 1'b0);
    check("pk_last_port", wr_port, 16'h4444);
    check("pk_last_req",  wr_req,  1'b1);

    // Queue full for 5 cycles while 0xBEEF is buffered.
    cyc(1'b1, 4'b0001, 4'hF, 64'h4444_3333_2222_BEEF, 1'b0);
    check("full_load_ack", req_ack, 4'b0001);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 4'b0010, 4'hF, D_BASE, 1'b1);
      check($sformatf("full_wr_req%0d", k), wr_req, 1'b0);
      check($sformatf("full_ack%0d", k), req_ack, 4'h0);
    end
    cyc(1'b1, 4'b0010, 4'hF, D_BASE, 1'b0);
    check("full_rel_req",  wr_req,  1'b1);
    check("full_rel_port", wr_port, 16'hBEEF);
    check("full_rel_ack",  req_ack, 4'b0010);
    cyc(1'b1, 4'h0, 4'hF, D_BASE, 1'b0);
    check("full_after_port", wr_port, 16'h2222);
    cyc(1'b1, 4'h0, 4'hF, D_BASE, 1'b0);
    check("full_after_req", wr_req, 1'b0);

    // Packet from req 1: lock, owner stall, then reset mid-packet.
    cyc(1'b1, 4'b0010, 4'b1101, 64'h4444_3333_3301_1111, 1'b0);
    check("lk_ack1", req_ack, 4'b0010);
    cyc(1'b1, 4'b0011, 4'b1101, 64'h4444_3333_3302_1111, 1'b0);
    check("lk_ack2_owner_only", req_ack, 4'b0010);
    check("lk_port1", wr_port, 16'h3301);
    cyc(1'b1, 4'b0001, 4'b1101, D_BASE, 1'b0);
    check("lk_stall_ack",  req_ack, 4'h0);
    check("lk_stall_port", wr_port, 16'h3302);
    cyc(1'b1, 4'b0001, 4'b1101, D_BASE, 1'b0);
    check("lk_stall_ack2", req_ack, 4'h0);
    check("lk_stall_req",  wr_req,  1'b0);
    cyc(1'b1, 4'b0011, 4'b1101, 64'h4444_3333_3303_1111, 1'b1);
    check("lk_fill_ack", req_ack, 4'b0010);
    cyc(1'b1, 4'b0011, 4'b1101, 64'h4444_3333_3304_1111, 1'b1);
    check("lk_full_ack", req_ack, 4'h0);
    check("lk_full_req", wr_req,  1'b0);
    cyc(1'b0, 4'b0011, 4'b1101, 64'h4444_3333_3304_1111, 1'b0);
    check("mrst_ack",  req_ack, 4'h0);
    check("mrst_req",  wr_req,  1'b0);
    check("mrst_port", wr_port, 16'h0);
    cyc(1'b1, 4'b0011, 4'b1101, 64'h4444_3333_3304_1111, 1'b0);
    check("mrst_next_ack", req_ack, 4'b0001);
    cyc(1'b1, 4'h0, 4'hF, D_BASE, 1'b0);
    check("mrst_next_port", wr_port, 16'h1111);
    check("mrst_next_req",  wr_req,  1'b1);

`ifdef QUEUE_ARB_STATS_EN
    // Statistics: 10 words from req 3 then 4 stalled cycles.
    cyc(1'b0, 4'h0, 4'hF, D_BASE, 1'b0);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, 4'b1000, 4'hF, D_BASE, 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 4'h0, 4'hF, D_BASE, 1'b1);
    end
    cyc(1'b1, 4'h0, 4'hF, D_BASE, 1'b0);
    check("stat_words3",     stat_words[3*32 +: 32], 32'd10);
    check("stat_words0",     stat_words[0 +: 32],    32'd0);
    check("stat_full_stall", stat_full_stall,        32'd4);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/queue_wr_arbiter.md
# queue_wr_arbiter

Round-robin arbiter that shares the single write port of the clock-crossing `queue` among `N_REQ` hash cores reporting results. Runs in the queue's write-clock domain. Holds one output word in a register and gates it against `q_full`. Supports multi-word packets: a grant is held until the packet's last word, so result records from different cores never interleave in the queue.

## Interface
- `N_REQ`, default 4: number of requesters, 2..16.
- `DATA_W`, default 16: word width; must equal the queue's `wr_port` width.
- `clk`  in  1: queue write clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  N_REQ: requester i has a word on its data slice.
- `req_last`  in  N_REQ: the offered word is the last of its packet.
- `req_data`  in  N_REQ*DATA_W: requester i word at bits [i*DATA_W +: DATA_W].
- `req_ack`  out  N_REQ: one-hot or zero; word of requester i consumed this cycle.
- `wr_port`  out  DATA_W: to queue `wr_port`.
- `wr_req`  out  1: to queue `wr_req`.
- `q_full`  in  1: from queue `q_full`.

## Operation
- Output register `ob_valid`/`ob_data`. `wr_req = ob_valid & ~q_full`; `wr_port = ob_data`.
- Load enable: `load = ~ob_valid | wr_req`. Exactly one word is accepted per cycle at most.
- FSM states:
  - IDLE: on `load`, pick requester via round-robin from `rr_ptr`. On an accepted word with `req_last=0`, go to LOCKED with `owner=i`. On `req_last=1`, stay in IDLE.
  - LOCKED: only `owner` is eligible; other requests wait. On accepting an owner word with `req_last=1`, return to IDLE.
- On any acceptance from requester i: `req_ack[i]=1` combinationally that cycle. `ob_data <= req_data[i]`, `ob_valid <= 1`, `rr_ptr <= (i+1) mod N_REQ`. `rr_ptr` does not move while LOCKED.
- If `load=1` and no eligible request: `ob_valid <= 0`, unless `wr_req=0`.
- Requesters hold `req_valid`/`req_data`/`req_last` stable until acked.

## Timing
- Reset values: `req_ack=0`, `wr_req=0`, `wr_port=0`, `ob_valid=0`, `rr_ptr=0`, state IDLE, `owner=0`.
- Latency: word acked in cycle t appears on `wr_req`/`wr_port` in t+1 if `q_full=0`.
- Throughput: one word per cycle while `q_full=0`. While `q_full=1`: `wr_req=0`, `ob` held, `req_ack=0`.
- `q_full` rising in the same cycle as a pending `ob_valid`: no write; the word is retained, not dropped.
- Owner drops `req_valid` while LOCKED: arbiter stalls in LOCKED and emits nothing. No timeout.
- Reset mid-packet: the `ob` word is discarded, state returns to IDLE, and the partial packet is not completed.
- Round-robin wrap: the search runs `rr_ptr`, `rr_ptr+1`, …, `N_REQ-1`, 0, … and starts fresh each cycle.

## Configuration
- `QUEUE_ARB_STATS_EN` defined:
  - Adds outputs `stat_words` (N_REQ*32, per-requester accepted-word counters).
  - Adds output `stat_full_stall` (32, cycles with `ob_valid & q_full`).
  - Counters are zero at reset and saturate at 2^32-1.
- Undefined: these ports and counters do not exist; function is otherwise identical.

## Structure
- Package `queue_arb_pkg`:
  - FSM state enum (IDLE, LOCKED).
  - `DATA_W_DEFAULT=16`.
  - Counter width constant `STAT_W=32`.
- Sub-module `rr_pick`: combinational round-robin priority encoder.
  - Inputs: eligible mask, `rr_ptr`.
  - Outputs: `grant_vld`, `grant_idx`.

## Test plan
- Reset held, all `req_valid=1` -> all outputs 0. After release, first ack goes to req 0, and `wr_port=req_data[0]` next cycle.
- All four valid, single-word packets, `q_full=0` -> ack order 0,1,2,3,0. One `wr_req` per cycle with matching data.
- Req 2 sends a 3-word packet (0xA1,0xA2,0xA3 last) while req 0/1 are valid -> queue receives A1,A2,A3 contiguously, then req 3 is next.
- `q_full=1` for 5 cycles with `ob` loaded 0xBEEF -> `wr_req=0` and no acks for 5 cycles. 0xBEEF is written exactly once after `q_full` falls.
- `reset_n` pulsed low mid-packet from req 1 -> state IDLE, `ob_valid=0`, and the next grant goes to req 0.
- With `QUEUE_ARB_STATS_EN`: 10 words from req 3 and 4 stall cycles -> `stat_words[3]=10`, `stat_full_stall=4`.
